// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment display scan path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: digit count, scan FSM state type, select reset value, anodes-off value.
package display_pkg;

   localparam int NUM_DIGITS = 4;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam logic [NUM_DIGITS-1:0] SEL_RESET = 4'b0001;
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Bundle of the digit scan controller's control inputs and display outputs.
// Latency: n/a (wires only).
// Backpressure: none; hold is a freeze request, not a handshake.
//
// Ports: hold, digit_en[3:0] (towards the scanner); sel[3:0], an[3:0], frame_tick (from it).
interface digit_scan_ctrl_if;
   import display_pkg::*;

   logic                  hold;
   logic [NUM_DIGITS-1:0] digit_en;
   logic [NUM_DIGITS-1:0] sel;
   logic [NUM_DIGITS-1:0] an;
   logic                  frame_tick;

   // master = the scanner itself
   modport master (
      input  hold,
      input  digit_en,
      output sel,
      output an,
      output frame_tick
   );

   // slave = whoever drives hold/digit_en and consumes sel/an/frame_tick
   modport slave (
      output hold,
      output digit_en,
      input  sel,
      input  an,
      input  frame_tick
   );

endinterface

// File: rtl/ring_counter4.sv
// One-hot 4-bit ring counter, rotates left by one whenever en is high.
// Latency: q updates one clock after en; wrap is combinational from en and q.
// Backpressure: none; en low simply holds q.
//
// Ports: clk, reset (sync, active-high, q -> 0001), en, q[3:0], wrap (=en & q[3]).
module ring_counter4
   import display_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   output logic [NUM_DIGITS-1:0] q,
   output logic                  wrap
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= SEL_RESET;
      end else if (en) begin
         q <= {q[NUM_DIGITS-2:0], q[NUM_DIGITS-1]};
      end
   end

   // high on the enabled step that takes 1000 back to 0001
   assign wrap = en & q[NUM_DIGITS-1];

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan: BLANK gap then SHOW dwell per digit, one-hot sel, active-low anodes.
// Latency: all outputs registered; an follows the next-state so it lights on the first SHOW cycle.
// Backpressure: hold freezes phase, state and sel; digit_en still masks an while held.
//
// Ports: clk, reset (sync, active-high), dsp (digit_scan_ctrl_if.master: hold, digit_en, sel, an, frame_tick).
module digit_scan_ctrl
   import display_pkg::*;
#(
   parameter int DWELL_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int CNT_W        = 17
) (
   input  logic               clk,
   input  logic               reset,
   digit_scan_ctrl_if.master  dsp
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   scan_state_t           state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  advance;
   logic [NUM_DIGITS-1:0] sel_q;
   logic                  wrap;
   logic [NUM_DIGITS-1:0] an_q, an_nxt;
   logic                  frame_tick_q;

   ring_counter4 u_ring (
      .clk   (clk),
      .reset (reset),
      .en    (advance),
      .q     (sel_q),
      .wrap  (wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= BLANK;
         cnt          <= '0;
         an_q         <= AN_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         an_q         <= an_nxt;
         // wrap is already gated by advance, which is low while held
         frame_tick_q <= wrap;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      advance   = 1'b0;
      if (!dsp.hold) begin
         case (state)
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = SHOW;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            SHOW: begin
               if (cnt == DWELL_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = BLANK;
                  advance   = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            default: begin
               cnt_nxt   = '0;
               state_nxt = BLANK;
            end
         endcase
      end
   end

   // sel only moves on SHOW->BLANK, so whenever the next state is SHOW the
   // current sel is also the next sel. Re-evaluating every cycle (held or not)
   // lets digit_en changes reach the anodes during hold.
   always_comb begin
      an_nxt = AN_OFF;
      if (state_nxt == SHOW) begin
         an_nxt = ~(sel_q & dsp.digit_en);
      end
   end

   assign dsp.sel        = sel_q;
   assign dsp.an         = an_q;
   assign dsp.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl with DWELL=4, BLANK=2.
// Reference model tracks elapsed un-held cycles since reset and derives
// slot, phase and expected outputs arithmetically.
module tb_digit_scan_ctrl;

   localparam int DW = 4;
   localparam int BL = 2;
   localparam int P  = DW + BL;     // digit period
   localparam int F  = 4 * P;       // frame period

   logic clk = 1'b0;
   logic reset = 1'b1;
   digit_scan_ctrl_if dif ();

   digit_scan_ctrl #(
      .DWELL_CYCLES (DW),
      .BLANK_CYCLES (BL),
      .CNT_W        (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .dsp   (dif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   int         t = 0;
   logic [3:0] den_q = 4'hf;
   logic       ft_m = 1'b0;
   logic [3:0] prev_an = 4'hf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] m_sel(input int tt);
      return 4'b0001 << ((tt / P) % 4);
   endfunction

   function automatic logic [3:0] m_an(input int tt, input logic [3:0] den);
      if ((tt % P) >= BL) return ~(m_sel(tt) & den);
      return 4'b1111;
   endfunction

   // Drive one cycle of inputs, advance the model, check all outputs.
   task automatic cycle(input logic r, input logic h, input logic [3:0] d);
      logic [3:0] a;
      @(negedge clk);
      reset = r;
      dif.hold = h;
      dif.digit_en = d;
      @(posedge clk);
      if (r) begin
         t = 0;
         ft_m = 1'b0;
      end else if (h) begin
         ft_m = 1'b0;
      end else begin
         t++;
         ft_m = ((t % F) == 0);
      end
      den_q = d;
      #1;
      a = dif.an;
      check("sel", dif.sel, m_sel(t));
      check("an", a, m_an(t, den_q));
      check("frame_tick", dif.frame_tick, ft_m);
      check("sel_onehot", $onehot(dif.sel), 1);
      check("an_multi_low", ($countones(~a) > 1), 0);
      // a different digit may never light on the cycle right after another
      check("no_gap", ((prev_an != 4'hf) && (a != 4'hf) && (a != prev_an)), 0);
      prev_an = a;
   endtask

   // Expected sequence from reset: 2 dark, 4 lit on digit 0, then dark on digit 1
   task automatic restart_seq();
      logic [3:0] exp_an [7];
      logic [3:0] exp_sel[7];
      exp_an  = '{4'hf, 4'hf, 4'he, 4'he, 4'he, 4'he, 4'hf};
      exp_sel = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2};
      check("rst_sel", dif.sel, exp_sel[0]);
      check("rst_an", dif.an, exp_an[0]);
      check("rst_ft", dif.frame_tick, 0);
      for (int k = 1; k < 7; k++) begin
         cycle(1'b0, 1'b0, 4'hf);
         check("seq_sel", dif.sel, exp_sel[k]);
         check("seq_an", dif.an, exp_an[k]);
      end
   endtask

   task automatic run_to(input int phase, input string tag);
      int guard = 0;
      while ((t % F) != phase && guard < 100) begin
         cycle(1'b0, 1'b0, 4'hf);
         guard++;
      end
      check(tag, (t % F), phase);
   endtask

   initial begin
      int ft_cnt, ft_bad, h1101, h0111, hbad, r;
      logic h;
      dif.hold = 1'b0;
      dif.digit_en = 4'hf;

      // 1: reset and first slot
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'hf);
      restart_seq();

      // 2: one full frame, a single frame_tick landing on sel=0001
      ft_cnt = 0;
      ft_bad = 0;
      for (int i = 0; i < F; i++) begin
         cycle(1'b0, 1'b0, 4'hf);
         if (dif.frame_tick) begin
            ft_cnt++;
            if (dif.sel != 4'b0001) ft_bad++;
         end
      end
      check("t2_ft_count", ft_cnt, 1);
      check("t2_ft_sel", ft_bad, 0);

      // 3: digit_en=1010 over a frame
      h1101 = 0; h0111 = 0; hbad = 0;
      for (int i = 0; i < F; i++) begin
         cycle(1'b0, 1'b0, 4'b1010);
         if (dif.an == 4'b1101) h1101++;
         if (dif.an == 4'b0111) h0111++;
         if (dif.an == 4'b1110 || dif.an == 4'b1011) hbad++;
      end
      check("t3_d1_lit", h1101, DW);
      check("t3_d3_lit", h0111, DW);
      check("t3_masked", hbad, 0);

      // 4: hold at SHOW cnt=1 of digit 2
      run_to(2 * P + BL + 1, "t4_reach");
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b1, 4'hf);
         check("t4_hold_sel", dif.sel, 4'b0100);
         check("t4_hold_an", dif.an, 4'b1011);
      end
      cycle(1'b0, 1'b0, 4'hf);
      check("t4_lit1", dif.an, 4'b1011);
      cycle(1'b0, 1'b0, 4'hf);
      check("t4_lit2", dif.an, 4'b1011);
      cycle(1'b0, 1'b0, 4'hf);
      check("t4_dark", dif.an, 4'b1111);
      check("t4_next_sel", dif.sel, 4'b1000);

      // 5: reset in the middle of digit 3's SHOW
      run_to(3 * P + BL + 1, "t5_reach");
      cycle(1'b1, 1'b0, 4'hf);
      restart_seq();

      // 6: random hold / digit_en / occasional reset
      for (int i = 0; i < 10000; i++) begin
         r = $urandom_range(0, 499);
         h = ($urandom_range(0, 3) == 0);
         cycle((r == 0), h, 4'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
